// File: rtl/fa_exhaustive_tester.sv
// Exhaustive stimulus/checker for a 1-bit full adder: walks all 8 {a,b,cin}
// vectors, holds each for STEP_CYCLES cycles, then checks sum/cout against the truth table.
module fa_exhaustive_tester #(
    parameter int STEP_CYCLES  = 4,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_fa_sum,
    input  logic       i_fa_cout,
    output logic       o_fa_a,
    output logic       o_fa_b,
    output logic       o_fa_cin,
    output logic [2:0] o_vec_idx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic       o_fail,
    output logic [2:0] o_err_idx,
    output logic [3:0] o_err_cnt
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

    state_t        r_state;
    logic          r_start_q;
    logic [CW-1:0] r_step;
    logic [2:0]    r_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_fail;
    logic [2:0]    r_err_idx;
    logic [3:0]    r_err_cnt;

    logic w_start_edge;
    logic w_exp_sum;
    logic w_exp_cout;
    logic w_mismatch;

    assign w_start_edge = i_start & ~r_start_q;
    assign w_exp_sum    = r_idx[2] ^ r_idx[1] ^ r_idx[0];
    assign w_exp_cout   = (r_idx[2] & r_idx[1]) | (r_idx[2] & r_idx[0]) | (r_idx[1] & r_idx[0]);
    assign w_mismatch   = {i_fa_cout, i_fa_sum} != {w_exp_cout, w_exp_sum};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_step    <= '0;
            r_idx     <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_err_idx <= 3'd0;
            r_err_cnt <= 4'd0;
        end else begin
            r_start_q <= i_start;
            case (r_state)
                // A start edge in DONE restarts exactly like one from IDLE.
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        r_state   <= S_APPLY;
                        r_step    <= '0;
                        r_idx     <= 3'd0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b0;
                        r_err_idx <= 3'd0;
                        r_err_cnt <= 4'd0;
                    end
                end
                S_APPLY: begin
                    if (r_step == STEP_LAST) r_state <= S_CHECK;
                    else                     r_step  <= r_step + CW'(1);
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + 4'd1;
                        r_fail    <= 1'b1;
                        if (!r_fail) r_err_idx <= r_idx;
                    end
                    if ((w_mismatch && STOP_ON_FAIL) || r_idx == 3'd7) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= ~(r_fail | w_mismatch);
                    end else begin
                        r_state <= S_APPLY;
                        r_step  <= '0;
                        r_idx   <= r_idx + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fa_a    = r_idx[2];
    assign o_fa_b    = r_idx[1];
    assign o_fa_cin  = r_idx[0];
    assign o_vec_idx = r_idx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_pass    = r_pass;
    assign o_fail    = r_fail;
    assign o_err_idx = r_err_idx;
    assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_fa_exhaustive_tester.sv
// Bench for fa_exhaustive_tester: two instances (run-all and stop-on-fail) driving a
// faultable full-adder model; expected run results queued at start, checked at done.
module tb_fa_exhaustive_tester;
    localparam int S = 4;

    typedef struct {
        int         sel;    // 0: run-all instance, 1: stop-on-fail instance
        int         fault;  // 0 ok, 1 sum stuck-0, 2 cout inverted, 3 cout stuck-1
        int         hold;   // cycles start is held high
        int         mid;    // cycle of an extra one-cycle start pulse (0 = none)
        int         exp_c;  // cycle count at which done first reads high
        logic [3:0] ecnt;
        logic [2:0] eidx;
        logic       epass;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    int   fault = 0;
    int   sel = 0;
    int   total = 0, bad = 0;

    logic       a0, b0, c0, a1, b1, c1, sum0, cout0, sum1, cout1;
    logic       busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
    logic [2:0] idx0, eidx0, idx1, eidx1;
    logic [3:0] ecnt0, ecnt1;

    always #5 clk = ~clk;

    function automatic logic [1:0] fa_model(input logic a, input logic b, input logic c, input int f);
        logic s, co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        case (f)
            1: s  = 1'b0;
            2: co = ~co;
            3: co = 1'b1;
            default: ;
        endcase
        return {co, s};
    endfunction

    assign {cout0, sum0} = fa_model(a0, b0, c0, fault);
    assign {cout1, sum1} = fa_model(a1, b1, c1, fault);

    fa_exhaustive_tester #(.STEP_CYCLES(S), .STOP_ON_FAIL(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_fa_sum(sum0), .i_fa_cout(cout0),
        .o_fa_a(a0), .o_fa_b(b0), .o_fa_cin(c0), .o_vec_idx(idx0), .o_busy(busy0),
        .o_done(done0), .o_pass(pass0), .o_fail(fail0), .o_err_idx(eidx0), .o_err_cnt(ecnt0));

    fa_exhaustive_tester #(.STEP_CYCLES(S), .STOP_ON_FAIL(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_fa_sum(sum1), .i_fa_cout(cout1),
        .o_fa_a(a1), .o_fa_b(b1), .o_fa_cin(c1), .o_vec_idx(idx1), .o_busy(busy1),
        .o_done(done1), .o_pass(pass1), .o_fail(fail1), .o_err_idx(eidx1), .o_err_cnt(ecnt1));

    // Selected-instance view
    logic       m_busy, m_done, m_pass, m_fail;
    logic [2:0] m_idx, m_eidx, m_stim;
    logic [3:0] m_ecnt;
    assign m_busy = sel != 0 ? busy1 : busy0;
    assign m_done = sel != 0 ? done1 : done0;
    assign m_pass = sel != 0 ? pass1 : pass0;
    assign m_fail = sel != 0 ? fail1 : fail0;
    assign m_idx  = sel != 0 ? idx1  : idx0;
    assign m_eidx = sel != 0 ? eidx1 : eidx0;
    assign m_ecnt = sel != 0 ? ecnt1 : ecnt0;
    assign m_stim = sel != 0 ? {a1, b1, c1} : {a0, b0, c0};

    vec_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input int s, input logic val);
        if (s != 0) start1 = val;
        else        start0 = val;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " idx"},  m_idx, 0);
        chk({tag, " stim"}, m_stim, 0);
        chk({tag, " busy"}, m_busy, 0);
        chk({tag, " done"}, m_done, 0);
        chk({tag, " pass"}, m_pass, 0);
        chk({tag, " fail"}, m_fail, 0);
        chk({tag, " eidx"}, m_eidx, 0);
        chk({tag, " ecnt"}, m_ecnt, 0);
    endtask

    task automatic run(input vec_t v);
        int   c;
        bit   seen;
        vec_t e;
        sel   = v.sel;
        fault = v.fault;
        seen  = 1'b0;
        @(negedge clk);
        set_start(v.sel, 1'b1);
        sb.push_back(v);
        for (c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("run start busy", m_busy, 1);
                chk("run start done", m_done, 0);
                chk("run start fail", m_fail, 0);
                chk("run start ecnt", m_ecnt, 0);
            end
            if (!seen && !m_done && (c - 1) % (S + 1) == 0) begin
                chk("vec idx", m_idx, (c - 1) / (S + 1));
                chk("vec stim", m_stim, (c - 1) / (S + 1));
            end
            if (!seen && m_done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("done cycle", c, e.exp_c);
                chk("err_cnt", m_ecnt, e.ecnt);
                chk("err_idx", m_eidx, e.eidx);
                chk("pass", m_pass, e.epass);
                chk("fail", m_fail, !e.epass);
                chk("busy at done", m_busy, 0);
            end
            set_start(v.sel, (c < v.hold) || (c == v.mid));
            if (seen && c >= v.hold && c > v.mid) break;
        end
        if (!seen) begin
            chk("done timeout", 0, 1);
            void'(sb.pop_front());
        end
        set_start(v.sel, 1'b0);
        @(negedge clk);
        chk("done held", m_done, 1);
    endtask

    vec_t tbl[9];

    initial begin
        int n;
        tbl[0] = '{0, 0, 1,   0,  41, 4'd0, 3'd0, 1'b1};  // fault-free
        tbl[1] = '{0, 1, 1,   0,  41, 4'd4, 3'd1, 1'b0};  // sum stuck-0
        tbl[2] = '{1, 2, 1,   0,   6, 4'd1, 3'd0, 1'b0};  // cout inverted, stop at idx0
        tbl[3] = '{0, 3, 1,   0,  41, 4'd4, 3'd0, 1'b0};  // cout stuck-1
        tbl[4] = '{1, 1, 1,   0,  11, 4'd1, 3'd1, 1'b0};  // sum stuck-0, stop at idx1
        tbl[5] = '{0, 0, 100, 0,  41, 4'd0, 3'd0, 1'b1};  // start held 100 cycles
        tbl[6] = '{0, 0, 1,   12, 41, 4'd0, 3'd0, 1'b1};  // extra pulse mid-run
        tbl[7] = '{0, 1, 1,   0,  41, 4'd4, 3'd1, 1'b0};  // leave a failing result...
        tbl[8] = '{0, 0, 1,   0,  41, 4'd0, 3'd0, 1'b1};  // ...then restart from DONE

        repeat (3) @(negedge clk);
        sel = 0; #1 check_zero("reset dut0");
        sel = 1; #1 check_zero("reset dut1");
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // Reset in the middle of a run
        sel = 0; fault = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        n = 0;
        while (idx0 != 3'd3 && n < 100) begin @(negedge clk); n++; end
        chk("reach idx3", idx0, 3);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid-run reset");
        rst = 1'b0;
        run(tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
